// File: rtl/fft_ctrl_pkg.sv
// Shared FSM encoding, width helpers and legal parameter ranges for the FFT control blocks.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package fft_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } fft_state_e;

   localparam int LOG2N_MIN  = 2;
   localparam int LOG2N_MAX  = 12;
   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 4;

   // Smallest r with 2**r >= value.
   function automatic int ceil_log2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < value) r = r + 1;
      end
      return r;
   endfunction

   // Bit width needed to hold 0..value-1, never less than one bit.
   function automatic int width_of(input int value);
      int w;
      w = ceil_log2(value);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth shift register aligning read-side strobes/addresses with write-back.
// Latency: DEPTH cycles from din to dout.
// Backpressure: none; shifts every cycle, async reset clears every stage.
module fft_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [DEPTH-1:0][WIDTH-1:0] pipe_q;
   logic [DEPTH-1:0][WIDTH-1:0] pipe_d;

   // Shift one stage per cycle, new data entering at index 0.
   always_comb begin
      pipe_d    = pipe_q;
      pipe_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   // Pipeline registers; reset flushes any in-flight write strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pipe_q <= '0;
      else     pipe_q <= pipe_d;
   end

   assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_bfly_scheduler.sv
// In-place radix-2 DIT butterfly sequencer: RAM/ROM read issue, butterfly enable, write-back.
// Latency: start to done = LOG2N*(N/2+RD_LAT)+1 cycles; write-back RD_LAT cycles after each read.
// Backpressure: none; start is ignored unless idle, reads are stalled RD_LAT cycles between stages.
module fft_bfly_scheduler
   import fft_ctrl_pkg::*;
#(
   parameter int LOG2N  = 3,
   parameter int RD_LAT = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   output logic                         busy,
   output logic                         done,
   output logic                         rd_en,
   output logic [LOG2N-1:0]             rd_addr_a,
   output logic [LOG2N-1:0]             rd_addr_b,
   output logic [LOG2N-2:0]             tw_addr,
   output logic                         bf_en,
   output logic                         wr_en,
   output logic [LOG2N-1:0]             wr_addr_a,
   output logic [LOG2N-1:0]             wr_addr_b,
   output logic [width_of(LOG2N)-1:0]   stage
);

   localparam int KW = LOG2N - 1;
   localparam int TW = LOG2N - 1;
   localparam int SW = width_of(LOG2N);
   localparam int FW = width_of(RD_LAT);
   localparam int DW = 1 + 2 * LOG2N;

   localparam logic [KW-1:0]    K_LAST     = KW'((1 << (LOG2N - 1)) - 1);
   localparam logic [SW-1:0]    STAGE_TOP  = SW'(LOG2N - 1);
   localparam logic [FW-1:0]    FLUSH_LAST = FW'(RD_LAT - 1);
   localparam logic [LOG2N-1:0] ONE        = LOG2N'(1);

   fft_state_e       state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic [SW-1:0]    stage_q, stage_d;
   logic [FW-1:0]    fcnt_q, fcnt_d;
   logic             rd_en_q, rd_en_d;
   logic [LOG2N-1:0] rd_addr_a_q, rd_addr_a_d;
   logic [LOG2N-1:0] rd_addr_b_q, rd_addr_b_d;
   logic [TW-1:0]    tw_q, tw_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [LOG2N-1:0] one_s, mask, kx, pos, grp, addr_a;
   logic [SW-1:0]    tw_shift;
   logic [DW-1:0]    wr_dat;

   // Next state: butterfly counter within a stage, flush counter, stage advance.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      stage_d = stage_q;
      fcnt_d  = fcnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_READ;
               k_d     = '0;
               stage_d = '0;
            end
         end
         ST_READ: begin
            if (k_q == K_LAST) begin
               state_d = ST_FLUSH;
               fcnt_d  = '0;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         ST_FLUSH: begin
            if (fcnt_q == FLUSH_LAST) begin
               k_d = '0;
               if (stage_q == STAGE_TOP) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_READ;
                  stage_d = stage_q + SW'(1);
               end
            end else begin
               fcnt_d = fcnt_q + FW'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            stage_d = '0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Registered-output decode from the upcoming state: pos/grp split by shift and mask only.
   always_comb begin
      one_s    = ONE << stage_d;
      mask     = one_s - ONE;
      kx       = {1'b0, k_d};
      pos      = kx & mask;
      grp      = kx >> stage_d;
      addr_a   = ((grp << stage_d) << 1) | pos;
      tw_shift = STAGE_TOP - stage_d;

      rd_en_d     = (state_d == ST_READ);
      busy_d      = (state_d == ST_READ) || (state_d == ST_FLUSH);
      done_d      = (state_d == ST_DONE);
      rd_addr_a_d = rd_en_d ? addr_a : '0;
      rd_addr_b_d = rd_en_d ? (addr_a | one_s) : '0;
      tw_d        = rd_en_d ? (TW'(pos) << tw_shift) : '0;
   end

   // Control and read-side registers; reset aborts any transform in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         k_q         <= '0;
         stage_q     <= '0;
         fcnt_q      <= '0;
         rd_en_q     <= 1'b0;
         rd_addr_a_q <= '0;
         rd_addr_b_q <= '0;
         tw_q        <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         stage_q     <= stage_d;
         fcnt_q      <= fcnt_d;
         rd_en_q     <= rd_en_d;
         rd_addr_a_q <= rd_addr_a_d;
         rd_addr_b_q <= rd_addr_b_d;
         tw_q        <= tw_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Write-back mirrors each read RD_LAT cycles later, when the butterfly sees its operands.
   fft_delay_line #(
      .WIDTH (DW),
      .DEPTH (RD_LAT)
   ) u_wr_align (
      .clk  (clk),
      .rst  (rst),
      .din  ({rd_en_q, rd_addr_a_q, rd_addr_b_q}),
      .dout (wr_dat)
   );

   assign busy      = busy_q;
   assign done      = done_q;
   assign rd_en     = rd_en_q;
   assign rd_addr_a = rd_addr_a_q;
   assign rd_addr_b = rd_addr_b_q;
   assign tw_addr   = tw_q;
   assign stage     = stage_q;
   assign wr_en     = wr_dat[DW-1];
   assign bf_en     = wr_dat[DW-1];
   assign wr_addr_a = wr_dat[2*LOG2N-1:LOG2N];
   assign wr_addr_b = wr_dat[LOG2N-1:0];

endmodule

// File: tb/tb_fft_bfly_scheduler.sv
// Directed bench for the butterfly scheduler: N=8/RD_LAT=1 and N=16/RD_LAT=3 instances.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_fft_bfly_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   // N=8, RD_LAT=1 instance
   logic       rst8, start8, d8_busy, d8_done, d8_rd_en, d8_bf_en, d8_wr_en;
   logic [2:0] d8_rd_a, d8_rd_b, d8_wr_a, d8_wr_b;
   logic [1:0] d8_tw, d8_stage;

   // N=16, RD_LAT=3 instance
   logic       rst16, start16, d16_busy, d16_done, d16_rd_en, d16_bf_en, d16_wr_en;
   logic [3:0] d16_rd_a, d16_rd_b, d16_wr_a, d16_wr_b;
   logic [2:0] d16_tw;
   logic [1:0] d16_stage;

   fft_bfly_scheduler #(.LOG2N(3), .RD_LAT(1)) dut8 (
      .clk(clk), .rst(rst8), .start(start8), .busy(d8_busy), .done(d8_done),
      .rd_en(d8_rd_en), .rd_addr_a(d8_rd_a), .rd_addr_b(d8_rd_b), .tw_addr(d8_tw),
      .bf_en(d8_bf_en), .wr_en(d8_wr_en), .wr_addr_a(d8_wr_a), .wr_addr_b(d8_wr_b),
      .stage(d8_stage)
   );

   fft_bfly_scheduler #(.LOG2N(4), .RD_LAT(3)) dut16 (
      .clk(clk), .rst(rst16), .start(start16), .busy(d16_busy), .done(d16_done),
      .rd_en(d16_rd_en), .rd_addr_a(d16_rd_a), .rd_addr_b(d16_rd_b), .tw_addr(d16_tw),
      .bf_en(d16_bf_en), .wr_en(d16_wr_en), .wr_addr_a(d16_wr_a), .wr_addr_b(d16_wr_b),
      .stage(d16_stage)
   );

   // Hand-derived N=8 read schedule, in issue order.
   int exp_a  [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
   int exp_b  [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
   int exp_tw [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

   // Sample RAM + twiddle ROM (Q14) + combinational butterfly around the N=8 instance.
   int ram_re [8];
   int ram_im [8];
   int tw_re  [4] = '{16384,  11585,      0, -11585};
   int tw_im  [4] = '{    0, -11585, -16384, -11585};
   int ca_re, ca_im, cb_re, cb_im, cw_re, cw_im;
   bit load_impulse = 1'b0;

   always @(negedge clk) begin
      int pr, pi;
      if (load_impulse) begin
         for (int i = 0; i < 8; i++) begin
            ram_re[i] = 0;
            ram_im[i] = 0;
         end
         ram_re[0] = 1000;
      end else begin
         if (d8_wr_en) begin
            pr = (cb_re * cw_re - cb_im * cw_im) >>> 14;
            pi = (cb_re * cw_im + cb_im * cw_re) >>> 14;
            ram_re[d8_wr_a] = ca_re + pr;
            ram_im[d8_wr_a] = ca_im + pi;
            ram_re[d8_wr_b] = ca_re - pr;
            ram_im[d8_wr_b] = ca_im - pi;
         end
         if (d8_rd_en) begin
            ca_re = ram_re[d8_rd_a];
            ca_im = ram_im[d8_rd_a];
            cb_re = ram_re[d8_rd_b];
            cb_im = ram_im[d8_rd_b];
            cw_re = tw_re[d8_tw];
            cw_im = tw_im[d8_tw];
         end
      end
   end

   task automatic test_reset();
      rst8 = 1'b1; rst16 = 1'b1; start8 = 1'b0; start16 = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if ({d8_busy, d8_done, d8_rd_en, d8_bf_en, d8_wr_en} !== 5'b0)
         $display("FAIL reset8 strobes: got %b want 00000", {d8_busy, d8_done, d8_rd_en, d8_bf_en, d8_wr_en}); else passes++;
      checks++; if ({d8_rd_a, d8_rd_b, d8_wr_a, d8_wr_b, d8_tw, d8_stage} !== 16'h0)
         $display("FAIL reset8 addrs: got %h want 0", {d8_rd_a, d8_rd_b, d8_wr_a, d8_wr_b, d8_tw, d8_stage}); else passes++;
      checks++; if ({d16_busy, d16_done, d16_rd_en, d16_bf_en, d16_wr_en} !== 5'b0)
         $display("FAIL reset16 strobes: got %b want 00000", {d16_busy, d16_done, d16_rd_en, d16_bf_en, d16_wr_en}); else passes++;
      checks++; if ({d16_rd_a, d16_rd_b, d16_wr_a, d16_wr_b, d16_tw, d16_stage} !== 21'h0)
         $display("FAIL reset16 addrs: got %h want 0", {d16_rd_a, d16_rd_b, d16_wr_a, d16_wr_b, d16_tw, d16_stage}); else passes++;
      rst8 = 1'b0; rst16 = 1'b0;
      @(negedge clk);
   endtask

   // Full N=8 schedule, write-back alignment and done timing.
   task automatic test_sequence_n8();
      bit pr_en; int pr_a, pr_b;
      pr_en = 0; pr_a = 0; pr_b = 0;
      @(negedge clk) start8 = 1'b1;
      @(negedge clk) start8 = 1'b0;
      for (int c = 1; c <= 17; c++) begin
         int s, p, idx; bit e_rd;
         s = (c - 1) / 5; p = (c - 1) % 5; idx = s * 4 + p;
         e_rd = (c <= 15) && (p < 4);
         checks++; if (d8_rd_en !== e_rd) $display("FAIL seq rd_en c%0d: got %b want %b", c, d8_rd_en, e_rd); else passes++;
         checks++; if (d8_busy !== (c <= 15)) $display("FAIL seq busy c%0d: got %b want %b", c, d8_busy, (c <= 15)); else passes++;
         checks++; if (d8_done !== (c == 16)) $display("FAIL seq done c%0d: got %b want %b", c, d8_done, (c == 16)); else passes++;
         checks++; if (d8_wr_en !== pr_en) $display("FAIL seq wr_en c%0d: got %b want %b", c, d8_wr_en, pr_en); else passes++;
         checks++; if (d8_bf_en !== pr_en) $display("FAIL seq bf_en c%0d: got %b want %b", c, d8_bf_en, pr_en); else passes++;
         if (c <= 15) begin
            checks++; if (d8_stage !== 2'(s)) $display("FAIL seq stage c%0d: got %0d want %0d", c, d8_stage, s); else passes++;
         end
         if (e_rd) begin
            checks++; if (d8_rd_a !== 3'(exp_a[idx]) || d8_rd_b !== 3'(exp_b[idx]) || d8_tw !== 2'(exp_tw[idx]))
               $display("FAIL seq rd c%0d: got (%0d,%0d) tw %0d want (%0d,%0d) tw %0d", c, d8_rd_a, d8_rd_b, d8_tw,
                        exp_a[idx], exp_b[idx], exp_tw[idx]); else passes++;
         end
         if (pr_en) begin
            checks++; if (d8_wr_a !== 3'(pr_a) || d8_wr_b !== 3'(pr_b))
               $display("FAIL seq wr c%0d: got (%0d,%0d) want (%0d,%0d)", c, d8_wr_a, d8_wr_b, pr_a, pr_b); else passes++;
         end
         pr_en = e_rd;
         pr_a  = e_rd ? exp_a[idx] : 0;
         pr_b  = e_rd ? exp_b[idx] : 0;
         @(negedge clk);
      end
   endtask

   // N=16, RD_LAT=3: flush length, RAW spacing between stages, done at 45.
   task automatic test_flush_n16();
      int nrd, nwr, done_cyc;
      int first_rd [4]; int last_rd [4]; int last_wr [4]; int st_at_first [4];
      nrd = 0; nwr = 0; done_cyc = -1;
      for (int i = 0; i < 4; i++) begin
         first_rd[i] = 0; last_rd[i] = 0; last_wr[i] = 0; st_at_first[i] = -1;
      end
      @(negedge clk) start16 = 1'b1;
      @(negedge clk) start16 = 1'b0;
      for (int c = 1; c <= 50; c++) begin
         if (d16_rd_en) begin
            nrd++;
            if (nrd <= 32) begin
               last_rd[(nrd - 1) / 8] = c;
               if ((nrd - 1) % 8 == 0) begin
                  first_rd[(nrd - 1) / 8] = c;
                  st_at_first[(nrd - 1) / 8] = int'(d16_stage);
               end
            end
         end
         if (d16_wr_en) begin
            nwr++;
            if (nwr <= 32) last_wr[(nwr - 1) / 8] = c;
         end
         if (d16_done && done_cyc < 0) done_cyc = c;
         @(negedge clk);
      end
      checks++; if (nrd != 32) $display("FAIL n16 reads: got %0d want 32", nrd); else passes++;
      checks++; if (nwr != 32) $display("FAIL n16 writes: got %0d want 32", nwr); else passes++;
      checks++; if (done_cyc != 45) $display("FAIL n16 done cycle: got %0d want 45", done_cyc); else passes++;
      checks++; if (last_wr[3] != 44) $display("FAIL n16 last write cycle: got %0d want 44", last_wr[3]); else passes++;
      for (int s = 0; s < 4; s++) begin
         checks++; if (st_at_first[s] != s) $display("FAIL n16 stage at first read %0d: got %0d want %0d", s, st_at_first[s], s); else passes++;
      end
      for (int s = 0; s < 3; s++) begin
         checks++; if (first_rd[s+1] - last_rd[s] - 1 != 3)
            $display("FAIL n16 flush gap %0d: got %0d want 3", s, first_rd[s+1] - last_rd[s] - 1); else passes++;
         checks++; if (first_rd[s+1] <= last_wr[s])
            $display("FAIL n16 raw %0d: got read c%0d want after write c%0d", s, first_rd[s+1], last_wr[s]); else passes++;
      end
   endtask

   // start while busy and in the DONE cycle must change nothing.
   task automatic test_start_ignored();
      @(negedge clk) start8 = 1'b1;
      @(negedge clk) start8 = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         checks++; if (d8_done !== (c == 16)) $display("FAIL ign done c%0d: got %b want %b", c, d8_done, (c == 16)); else passes++;
         if (c == 4) begin
            checks++; if (d8_rd_a !== 3'd6 || d8_rd_b !== 3'd7) $display("FAIL ign rd c4: got (%0d,%0d) want (6,7)", d8_rd_a, d8_rd_b); else passes++;
         end
         if (c == 6) begin
            checks++; if (d8_stage !== 2'd1 || d8_rd_a !== 3'd0 || d8_rd_b !== 3'd2)
               $display("FAIL ign c6: got s%0d (%0d,%0d) want s1 (0,2)", d8_stage, d8_rd_a, d8_rd_b); else passes++;
         end
         if (c >= 17) begin
            checks++; if (d8_busy !== 1'b0 || d8_rd_en !== 1'b0)
               $display("FAIL ign idle c%0d: got busy %b rd_en %b want 0 0", c, d8_busy, d8_rd_en); else passes++;
         end
         start8 = (c == 3) || (c == 16);
         @(negedge clk);
      end
      start8 = 1'b0;
   endtask

   // start in the IDLE cycle right after done is accepted.
   task automatic test_back_to_back();
      @(negedge clk) start8 = 1'b1;
      @(negedge clk) start8 = 1'b0;
      for (int c = 1; c <= 34; c++) begin
         if (c >= 16) begin
            checks++; if (d8_done !== (c == 16 || c == 33)) $display("FAIL b2b done c%0d: got %b want %b", c, d8_done, (c == 16 || c == 33)); else passes++;
         end
         if (c == 17) begin
            checks++; if (d8_busy !== 1'b0) $display("FAIL b2b busy c17: got %b want 0", d8_busy); else passes++;
         end
         if (c == 18) begin
            checks++; if (d8_busy !== 1'b1 || d8_rd_en !== 1'b1 || d8_rd_a !== 3'd0 || d8_rd_b !== 3'd1 || d8_stage !== 2'd0)
               $display("FAIL b2b restart c18: got busy %b rd %b (%0d,%0d) s%0d want 1 1 (0,1) s0",
                        d8_busy, d8_rd_en, d8_rd_a, d8_rd_b, d8_stage); else passes++;
         end
         start8 = (c == 17);
         @(negedge clk);
      end
      start8 = 1'b0;
   endtask

   // Async reset during stage 1 clears outputs at once and kills pending writes.
   task automatic test_reset_mid();
      @(negedge clk) start8 = 1'b1;
      @(negedge clk) start8 = 1'b0;
      repeat (6) @(negedge clk);
      checks++; if (d8_stage !== 2'd1 || d8_rd_en !== 1'b1) $display("FAIL rmid pre c7: got s%0d rd %b want s1 1", d8_stage, d8_rd_en); else passes++;
      #1 rst8 = 1'b1;
      #1;
      checks++; if ({d8_busy, d8_done, d8_rd_en, d8_bf_en, d8_wr_en} !== 5'b0)
         $display("FAIL rmid strobes: got %b want 00000", {d8_busy, d8_done, d8_rd_en, d8_bf_en, d8_wr_en}); else passes++;
      checks++; if ({d8_rd_a, d8_rd_b, d8_wr_a, d8_wr_b, d8_tw, d8_stage} !== 16'h0)
         $display("FAIL rmid addrs: got %h want 0", {d8_rd_a, d8_rd_b, d8_wr_a, d8_wr_b, d8_tw, d8_stage}); else passes++;
      repeat (2) @(negedge clk);
      rst8 = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         checks++; if (d8_wr_en !== 1'b0 || d8_busy !== 1'b0)
            $display("FAIL rmid after c%0d: got wr_en %b busy %b want 0 0", c, d8_wr_en, d8_busy); else passes++;
      end
   endtask

   // Clean run with the RAM model: impulse at x[0] gives a flat spectrum.
   task automatic test_impulse_fft();
      int done_cyc;
      done_cyc = -1;
      #1 load_impulse = 1'b1;
      @(negedge clk);
      #1 load_impulse = 1'b0;
      @(negedge clk) start8 = 1'b1;
      @(negedge clk) start8 = 1'b0;
      for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
         if (d8_done) done_cyc = c;
         else @(negedge clk);
      end
      checks++; if (done_cyc != 16) $display("FAIL fft done cycle: got %0d want 16", done_cyc); else passes++;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         checks++; if (ram_re[i] < 999 || ram_re[i] > 1001 || ram_im[i] < -1 || ram_im[i] > 1)
            $display("FAIL fft bin %0d: got (%0d,%0d) want (1000,0)", i, ram_re[i], ram_im[i]); else passes++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_sequence_n8();
      test_flush_n16();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid();
      test_impulse_fft();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
